// File: rtl/msrv32_pipe_ctrl_if.sv
// Signal bundle between the msrv32 pipeline sequencer and the rest of the core.
// The "slave" side is the sequencer itself; the "master" side is the core
// (stage-3 decode, data bus, CSR file) that feeds it and consumes its controls.
// Data-bus handshake: mem_req_in is held by stage 3 for as long as the access is
// outstanding; the transfer completes in the cycle where mem_ack_in is high.
// mem_req_in together with mem_ack_in in the same cycle is a zero-wait access.
interface msrv32_pipe_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   branch_taken_in;
   logic                   mem_req_in;
   logic                   mem_ack_in;
   logic                   trap_in;
   logic                   irq_pending_in;
   logic                   mret_in;
   logic                   pipe_en_out;
   logic                   flush_out;
   logic [1:0]             pc_src_out;
   logic                   trap_taken_out;
   logic                   mcause_sel_out;
   logic                   bus_err_out;
   logic [1:0]             state_out;
   logic [STALL_CNT_W-1:0] stall_count_out;

   modport slave (
      input  branch_taken_in, mem_req_in, mem_ack_in, trap_in, irq_pending_in, mret_in,
      output pipe_en_out, flush_out, pc_src_out, trap_taken_out, mcause_sel_out,
             bus_err_out, state_out, stall_count_out
   );

   modport master (
      output branch_taken_in, mem_req_in, mem_ack_in, trap_in, irq_pending_in, mret_in,
      input  pipe_en_out, flush_out, pc_src_out, trap_taken_out, mcause_sel_out,
             bus_err_out, state_out, stall_count_out
   );
endinterface

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline sequencer for the msrv32 two-stage core: drives PC / pipeline
// register enable and flush, selects the next-PC source, detects data-bus
// timeouts and keeps a saturating count of memory stall cycles.
module msrv32_pipe_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int STALL_CNT_W    = 16
) (
   input logic clk_in,
   input logic reset_in,
   msrv32_pipe_ctrl_if.slave bus
);

   localparam int WCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IADDR = 2'b01;
   localparam logic [1:0] PC_TRAP  = 2'b10;
   localparam logic [1:0] PC_MEPC  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_WAIT  = 2'b10,
      ST_FLUSH = 2'b11
   } state_t;

   state_t                 state, state_next;
   logic [WCNT_W-1:0]      wait_cnt, wait_cnt_next;
   logic [STALL_CNT_W-1:0] stall_cnt;

   logic       pipe_en;
   logic       flush;
   logic [1:0] pc_src;
   logic       trap_taken;
   logic       mcause_sel;
   logic       bus_err;

   // State and wait-counter registers.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state and control decode; RUN arbitration is strictly prioritised.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      pipe_en       = 1'b0;
      flush         = 1'b0;
      pc_src        = PC_PLUS4;
      trap_taken    = 1'b0;
      mcause_sel    = 1'b0;
      bus_err       = 1'b0;
      case (state)
         ST_IDLE: begin
            flush      = 1'b1;
            state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            pipe_en    = 1'b1;
            flush      = 1'b1;
            state_next = ST_RUN;
         end
         ST_RUN: begin
            if (bus.trap_in || bus.irq_pending_in) begin
               pipe_en    = 1'b1;
               flush      = 1'b1;
               pc_src     = PC_TRAP;
               trap_taken = 1'b1;
               mcause_sel = ~bus.trap_in & bus.irq_pending_in;
               state_next = ST_FLUSH;
            end else if (bus.mret_in) begin
               pipe_en    = 1'b1;
               flush      = 1'b1;
               pc_src     = PC_MEPC;
               state_next = ST_FLUSH;
            end else if (bus.mem_req_in && !bus.mem_ack_in) begin
               wait_cnt_next = '0;
               state_next    = ST_WAIT;
            end else if (bus.branch_taken_in) begin
               pipe_en = 1'b1;
               flush   = 1'b1;
               pc_src  = PC_IADDR;
            end else begin
               pipe_en = 1'b1;
            end
         end
         ST_WAIT: begin
            // Control-flow inputs are ignored while the bus access is pending.
            if (bus.mem_ack_in) begin
               pipe_en       = 1'b1;
               wait_cnt_next = '0;
               state_next    = ST_RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               bus_err       = 1'b1;
               trap_taken    = 1'b1;
               pc_src        = PC_TRAP;
               pipe_en       = 1'b1;
               flush         = 1'b1;
               wait_cnt_next = '0;
               state_next    = ST_FLUSH;
            end else begin
               wait_cnt_next = wait_cnt + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Saturating count of cycles where RUN/WAIT held the pipeline.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         stall_cnt <= '0;
      end else if ((state == ST_RUN || state == ST_WAIT) && !pipe_en && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.pipe_en_out     = pipe_en;
   assign bus.flush_out       = flush;
   assign bus.pc_src_out      = pc_src;
   assign bus.trap_taken_out  = trap_taken;
   assign bus.mcause_sel_out  = mcause_sel;
   assign bus.bus_err_out     = bus_err;
   assign bus.state_out       = state;
   assign bus.stall_count_out = stall_cnt;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Self-checking bench for msrv32_pipe_ctrl: per-cycle expected control vectors
// go through a scoreboard queue and are compared against the DUT outputs.
module tb_msrv32_pipe_ctrl;

   localparam int TIMEOUT_CYCLES = 16;
   localparam int STALL_CNT_W    = 5;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_WAIT  = 2'b10;
   localparam logic [1:0] S_FLUSH = 2'b11;

   logic clk;
   logic rst;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8:0] exp_q[$];

   msrv32_pipe_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

   msrv32_pipe_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .STALL_CNT_W   (STALL_CNT_W)
   ) dut (
      .clk_in  (clk),
      .reset_in(rst),
      .bus     (bus.slave)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", tag, obs, exp);
   endtask

   // Packs {state, pipe_en, flush, pc_src, trap_taken, mcause_sel, bus_err}.
   function automatic logic [8:0] ev(input logic [1:0] st, input logic pe, input logic fl,
                                     input logic [1:0] pc, input logic tt, input logic mc,
                                     input logic be);
      return {st, pe, fl, pc, tt, mc, be};
   endfunction

   function automatic logic [8:0] observed();
      return {bus.state_out, bus.pipe_en_out, bus.flush_out, bus.pc_src_out,
              bus.trap_taken_out, bus.mcause_sel_out, bus.bus_err_out};
   endfunction

   // Drives one cycle of inputs (called just after a falling edge), checks the
   // combinational outputs, then advances to the next falling edge.
   task automatic step(input string tag, input logic tr, input logic irq, input logic mr,
                       input logic br, input logic req, input logic ack, input logic [8:0] exp);
      logic [8:0] e;
      bus.trap_in         = tr;
      bus.irq_pending_in  = irq;
      bus.mret_in         = mr;
      bus.branch_taken_in = br;
      bus.mem_req_in      = req;
      bus.mem_ack_in      = ack;
      exp_q.push_back(exp);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, 32'(observed()), 32'(e));
      end
      @(negedge clk);
   endtask

   task automatic idle_step(input string tag, input logic [8:0] exp);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
   endtask

   // Reset-release sequence: IDLE, FLUSH, then RUN.
   task automatic startup(input string tag);
      idle_step({tag, "_idle"},  ev(S_IDLE,  1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_step({tag, "_flush"}, ev(S_FLUSH, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_step({tag, "_run"},   ev(S_RUN,   1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic flush_then_run(input string tag);
      idle_step({tag, "_flush"}, ev(S_FLUSH, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_step({tag, "_run"},   ev(S_RUN,   1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
   endtask

   // Stall entry followed by TIMEOUT_CYCLES-1 WAIT hold cycles with random
   // (ignored) control-flow inputs.
   task automatic stall_hold(input string tag);
      step({tag, "_enter"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
           ev(S_RUN, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
         step({tag, "_hold"}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0,
              ev(S_WAIT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.trap_in         = 1'b0;
      bus.irq_pending_in  = 1'b0;
      bus.mret_in         = 1'b0;
      bus.branch_taken_in = 1'b0;
      bus.mem_req_in      = 1'b0;
      bus.mem_ack_in      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      idle_step("in_reset", ev(S_IDLE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0));
      check("stall_reset", 32'(bus.stall_count_out), 32'd0);
      rst = 1'b0;
      startup("rst1");

      // Three wait states then ack.
      step("st3_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_RUN,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      step("st3_w0",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_WAIT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      step("st3_w1",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_WAIT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      step("st3_ack",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(S_WAIT, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_step("st3_run", ev(S_RUN, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      check("stall_after3", 32'(bus.stall_count_out), 32'd3);

      // Bus timeout.
      stall_hold("tmo");
      step("tmo_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_WAIT, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1));
      flush_then_run("tmo");
      check("stall_after_tmo", 32'(bus.stall_count_out), 32'd19);

      // Ack on the timeout cycle wins; stall counter saturates.
      stall_hold("lateack");
      step("lateack_ack", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ev(S_WAIT, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      idle_step("lateack_run", ev(S_RUN, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      check("stall_saturated", 32'(bus.stall_count_out), 32'd31);
      step("sat_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_RUN,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      step("sat_ack",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(S_WAIT, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      check("stall_held_sat", 32'(bus.stall_count_out), 32'd31);

      // Trap beats irq and branch; mcause reports exception.
      step("trap_all", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_RUN, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0));
      flush_then_run("trap_all");
      step("irq_only", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ev(S_RUN, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0));
      flush_then_run("irq_only");

      // mret beats a pending stall; then branches.
      step("mret", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ev(S_RUN, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0));
      flush_then_run("mret");
      step("branch",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(S_RUN, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0));
      step("branch_mem", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ev(S_RUN, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0));
      step("mem_zero_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(S_RUN, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      check("stall_unchanged", 32'(bus.stall_count_out), 32'd31);

      // Asynchronous reset in the middle of WAIT.
      step("ar_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_RUN,  1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      step("ar_wait",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(S_WAIT, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
      #2;
      rst = 1'b1;
      #1;
      check("ar_ctrl", 32'(observed()), 32'(ev(S_IDLE, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0)));
      check("ar_stall", 32'(bus.stall_count_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      startup("rst2");
      check("stall_after_rst2", 32'(bus.stall_count_out), 32'd0);

      // Report.
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
